// File: rtl/seg_req_arbiter.sv
// seg_req_arbiter: shares one 7-segment digit among eight requesters.
// A winner is chosen by fixed priority (highest index) or round-robin.
// The winner keeps the grant for a bounded tenure, and its index is shown
// on the digit using active-low segments.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   mode       0 = fixed priority, 1 = round-robin (sampled at arbitration)
//   req[7:0]   level-sensitive request lines
//   gnt[7:0]   one-hot grant (registered)
//   gnt_idx    index of the current or last winner (registered)
//   gnt_valid  high while a grant is active (registered)
//   timeout    one-cycle pulse when a tenure hits MAX_HOLD (registered)
//   seg[7:0]   active-low segment pattern of gnt_idx; 8'hFF when no grant
module seg_req_arbiter #(
  parameter int unsigned MAX_HOLD = 16,  // legal range 1..255
  parameter int unsigned CNT_W    = 8    // must be able to hold MAX_HOLD-1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       mode,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [7:0] seg
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] last, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [7:0]       gnt_n;
  logic [IDX_W-1:0] gnt_idx_n;
  logic             gnt_valid_n;
  logic             timeout_n;
  logic [7:0]       seg_n;

  logic [IDX_W-1:0] fp_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] rr_cand;
  logic             rr_hit;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;

  // Active-low segment pattern for one digit 0..7
  function automatic logic [7:0] seg_enc(input logic [IDX_W-1:0] d);
    logic [7:0] p;
    case (d)
      3'd0:    p = 8'b0000_0010;
      3'd1:    p = 8'b1001_1111;
      3'd2:    p = 8'b0010_0101;
      3'd3:    p = 8'b0000_1101;
      3'd4:    p = 8'b1001_1001;
      3'd5:    p = 8'b0100_1001;
      3'd6:    p = 8'b0100_0001;
      default: p = 8'b0001_1111;
    endcase
    return p;
  endfunction

  // Winner selection: highest set index, or first set bit after last
  always_comb begin
    fp_idx  = '0;
    rr_idx  = '0;
    rr_cand = '0;
    rr_hit  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) fp_idx = IDX_W'(i);
    end
    // k = N_REQ wraps back to last itself, so a lone requester can repeat
    for (int k = 1; k <= N_REQ; k++) begin
      rr_cand = last + IDX_W'(k);
      if (!rr_hit && req[rr_cand]) begin
        rr_idx = rr_cand;
        rr_hit = 1'b1;
      end
    end
    any_req = |req;
    win_idx = mode ? rr_idx : fp_idx;
  end

  // Next state and next registered outputs
  always_comb begin
    state_n     = state;
    last_n      = last;
    cnt_n       = cnt;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;
    seg_n       = seg;

    case (state)
      // GAP's exit edge also arbitrates, so a release costs exactly one
      // cycle without grant before the next winner is shown.
      IDLE, GAP: begin
        if (any_req) begin
          state_n     = GRANT;
          cnt_n       = '0;
          gnt_n       = 8'b1 << win_idx;
          gnt_idx_n   = win_idx;
          gnt_valid_n = 1'b1;
          seg_n       = seg_enc(win_idx);
        end else begin
          state_n     = IDLE;
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          seg_n       = SEG_BLANK;
        end
      end

      GRANT: begin
        // A dropped request wins over the hold limit, so no timeout then
        if (!req[gnt_idx] || (cnt == HOLD_LAST)) begin
          state_n     = GAP;
          last_n      = gnt_idx;
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          seg_n       = SEG_BLANK;
          timeout_n   = req[gnt_idx];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n     = IDLE;
        gnt_n       = '0;
        gnt_valid_n = 1'b0;
        seg_n       = SEG_BLANK;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      last      <= 3'd7;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      seg       <= SEG_BLANK;
    end else begin
      state     <= state_n;
      last      <= last_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
      seg       <= seg_n;
    end
  end

endmodule

// File: tb/tb_seg_req_arbiter.sv
// Directed bench for seg_req_arbiter. Four instances with MAX_HOLD of
// 16, 2, 4 and 1 share clock and reset; each has its own req and mode.
module tb_seg_req_arbiter;

  logic       clk;
  logic       resetn;
  logic       mode      [4];
  logic [7:0] req       [4];
  logic [7:0] gnt       [4];
  logic [2:0] gnt_idx   [4];
  logic       gnt_valid [4];
  logic       timeout   [4];
  logic [7:0] seg       [4];

  int total = 0;
  int bad   = 0;

  logic [7:0] seg_tab [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    seg_req_arbiter #(
      .MAX_HOLD(i == 0 ? 16 : i == 1 ? 2 : i == 2 ? 4 : 1),
      .CNT_W   (8)
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .mode     (mode[i]),
      .req      (req[i]),
      .gnt      (gnt[i]),
      .gnt_idx  (gnt_idx[i]),
      .gnt_valid(gnt_valid[i]),
      .timeout  (timeout[i]),
      .seg      (seg[i])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tab[0] = 8'b0000_0010;
    seg_tab[1] = 8'b1001_1111;
    seg_tab[2] = 8'b0010_0101;
    seg_tab[3] = 8'b0000_1101;
    seg_tab[4] = 8'b1001_1001;
    seg_tab[5] = 8'b0100_1001;
    seg_tab[6] = 8'b0100_0001;
    seg_tab[7] = 8'b0001_1111;
    for (int i = 0; i < 4; i++) begin
      mode[i] = 1'b0;
      req[i]  = 8'h00;
    end

    // Reset held with all requests high, then first grant goes to 7
    resetn = 1'b0;
    req[0] = 8'hFF;
    step();
    chk("rst1_gnt", 32'(gnt[0]), 32'h00);
    chk("rst1_seg", 32'(seg[0]), 32'hFF);
    chk("rst1_val", 32'(gnt_valid[0]), 32'd0);
    step();
    chk("rst2_gnt", 32'(gnt[0]), 32'h00);
    chk("rst2_seg", 32'(seg[0]), 32'hFF);
    chk("rst2_to", 32'(timeout[0]), 32'd0);
    resetn = 1'b1;
    step();
    chk("first_gnt", 32'(gnt[0]), 32'h80);
    chk("first_idx", 32'(gnt_idx[0]), 32'd7);
    chk("first_seg", 32'(seg[0]), 32'h1F);
    chk("first_val", 32'(gnt_valid[0]), 32'd1);
    req[0] = 8'h00;
    step();
    chk("first_rel", 32'(gnt[0]), 32'h00);
    chk("first_rel_idx", 32'(gnt_idx[0]), 32'd7);
    step();

    // Fixed priority with request drop
    req[0] = 8'b0010_0100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fp_gnt5", 32'(gnt[0]), 32'h20);
    end
    chk("fp_seg5", 32'(seg[0]), 32'(seg_tab[5]));
    req[0] = 8'b0000_0100;
    step();
    chk("fp_gap_gnt", 32'(gnt[0]), 32'h00);
    chk("fp_gap_seg", 32'(seg[0]), 32'hFF);
    chk("fp_gap_to", 32'(timeout[0]), 32'd0);
    step();
    chk("fp_gnt2", 32'(gnt[0]), 32'h04);
    chk("fp_idx2", 32'(gnt_idx[0]), 32'd2);
    chk("fp_seg2", 32'(seg[0]), 32'h25);
    req[0] = 8'h00;
    step();
    step();

    // Timeout after 16 cycles, then index 3 is granted again
    req[0] = 8'h08;
    for (int c = 0; c < 16; c++) begin
      step();
      chk("to_hold", 32'(gnt[0]), 32'h08);
      chk("to_hold_to", 32'(timeout[0]), 32'd0);
    end
    step();
    chk("to_gap_gnt", 32'(gnt[0]), 32'h00);
    chk("to_pulse", 32'(timeout[0]), 32'd1);
    step();
    chk("to_regnt", 32'(gnt[0]), 32'h08);
    chk("to_regnt_idx", 32'(gnt_idx[0]), 32'd3);
    chk("to_pulse_end", 32'(timeout[0]), 32'd0);
    req[0] = 8'h00;
    step();
    step();

    // Round-robin fairness on the MAX_HOLD=2 instance, starting from reset
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    mode[1] = 1'b1;
    req[1]  = 8'hFF;
    step();
    for (int w = 0; w < 9; w++) begin
      chk("rr_gnt_a", 32'(gnt[1]), 32'(8'b1 << (w % 8)));
      chk("rr_idx", 32'(gnt_idx[1]), 32'(w % 8));
      chk("rr_seg", 32'(seg[1]), 32'(seg_tab[w % 8]));
      step();
      chk("rr_gnt_b", 32'(gnt[1]), 32'(8'b1 << (w % 8)));
      step();
      chk("rr_gap", 32'(gnt[1]), 32'h00);
      chk("rr_to", 32'(timeout[1]), 32'd1);
      step();
    end
    req[1] = 8'h00;
    step();
    step();
    step();

    // Mode switch mid-tenure is ignored; reset mid-tenure restores last=7
    req[0] = 8'h40;
    step();
    chk("mt_gnt6", 32'(gnt[0]), 32'h40);
    step();
    mode[0] = 1'b1;
    step();
    chk("mt_gnt6_hold", 32'(gnt[0]), 32'h40);
    chk("mt_idx6_hold", 32'(gnt_idx[0]), 32'd6);
    req[0] = 8'h00;
    step();
    chk("mt_gap", 32'(gnt[0]), 32'h00);
    req[0] = 8'h40;
    step();
    chk("mt_rr6", 32'(gnt[0]), 32'h40);
    resetn = 1'b0;
    req[0] = 8'h41;
    step();
    chk("mt_rst_gnt", 32'(gnt[0]), 32'h00);
    chk("mt_rst_seg", 32'(seg[0]), 32'hFF);
    chk("mt_rst_val", 32'(gnt_valid[0]), 32'd0);
    resetn = 1'b1;
    step();
    chk("mt_rr_gnt0", 32'(gnt[0]), 32'h01);
    chk("mt_rr_idx0", 32'(gnt_idx[0]), 32'd0);
    chk("mt_rr_seg0", 32'(seg[0]), 32'h02);
    req[0]  = 8'h00;
    mode[0] = 1'b0;
    step();
    step();

    // Request drop on the last allowed cycle (MAX_HOLD=4): no timeout
    req[2] = 8'h10;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("sim_hold", 32'(gnt[2]), 32'h10);
    end
    req[2] = 8'h00;
    step();
    chk("sim_rel_gnt", 32'(gnt[2]), 32'h00);
    chk("sim_rel_to", 32'(timeout[2]), 32'd0);
    chk("sim_rel_idx", 32'(gnt_idx[2]), 32'd4);
    step();

    // MAX_HOLD=1: one-cycle tenures, timeout while request stays high
    req[3] = 8'h01;
    step();
    chk("h1_gnt", 32'(gnt[3]), 32'h01);
    step();
    chk("h1_gap", 32'(gnt[3]), 32'h00);
    chk("h1_to", 32'(timeout[3]), 32'd1);
    step();
    chk("h1_regnt", 32'(gnt[3]), 32'h01);
    chk("h1_to_end", 32'(timeout[3]), 32'd0);
    req[3] = 8'h00;
    step();
    chk("h1_drop_gnt", 32'(gnt[3]), 32'h00);
    chk("h1_drop_to", 32'(timeout[3]), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
